apb_gpio_slave: RTL
===================

// Module: apb_gpio_slave
// PURPOSE
//  APB3 completer on the PSEL1 (GPIO) select of the APB master; consumes PADDR/PWDATA/PWRITE/PENABLE,
//  returns PRDATA/PREADY/PSLVERR. Holds a GPIO register bank: output data, direction, synchronised
//  inputs, per-pin edge interrupts. Programmable wait states exercise the master's ACCESS-phase stall.
// PARAMETERS
//  N_GPIO       32  pin count (1..32); unused data bits read 0, writes ignored
//  WAIT_CYCLES  0   PREADY-low cycles inserted in each ACCESS phase (0..15)
//  ADDR_W       32  PADDR width; only PADDR[4:2] decoded
// PORTS
//  PCLK      in   1       clock, all logic rising-edge
//  PRESET    in   1       synchronous, active-high reset
//  PSEL      in   1       completer select (master PSEL1)
//  PENABLE   in   1       access phase
//  PWRITE    in   1       1=write, 0=read
//  PADDR     in   ADDR_W  byte address
//  PWDATA    in   32      write data
//  PRDATA    out  32      read data, valid when PREADY=1
//  PREADY    out  1       transfer completes this cycle
//  PSLVERR   out  1       error response, valid only with PREADY=1
//  gpio_in   in   N_GPIO  asynchronous pad inputs
//  gpio_out  out  N_GPIO  output data register
//  gpio_oe   out  N_GPIO  direction register (1=drive)
//  irq       out  1       level interrupt = |(IRQ_STAT & IRQ_EN)
// BEHAVIOUR
//  Reset (PRESET=1 at edge): all registers 0, FSM IDLE, sync/edge flops 0; PREADY=0, PSLVERR=0, PRDATA=0, irq=0.
//  Registers (PADDR[4:2]): 0x00 DOUT rw | 0x04 DIR rw | 0x08 DIN ro | 0x0C IRQ_EN rw | 0x10 IRQ_STAT w1c
//    | 0x14 IRQ_POL rw (1=rising, 0=falling). Offsets 0x18/0x1C invalid. PADDR[1:0] ignored.
//  FSM: IDLE -> (PSEL & !PENABLE) -> SETUP: latch addr/dir/wdata, cnt<=WAIT_CYCLES -> WAIT.
//    WAIT: if PSEL&PENABLE: cnt>0 -> PREADY=0, cnt--; cnt==0 -> PREADY=1, commit, -> IDLE.
//    PSEL dropped in WAIT/SETUP -> IDLE, no commit. Back-to-back SETUP straight after completion accepted.
//  Latency: WAIT_CYCLES=0 -> PREADY=1 in first ACCESS cycle; else PREADY in ACCESS cycle WAIT_CYCLES+1.
//  PREADY combinational from FSM/cnt; PRDATA/PSLVERR combinational from latched addr, 0 when PREADY=0.
//  Write commits only on the PREADY=1 cycle; read value sampled same cycle.
//  PSLVERR=1: invalid offset, or write to DIN. No state change on error; reads return 0.
//  DIN = 2-flop synchroniser output; edge detect vs. previous synced value (3rd flop).
//  IRQ_STAT[i] set on matching edge regardless of IRQ_EN; W1C clears. Set and W1C same cycle: set wins.
//  DOUT written while DIR=0 retains value; gpio_out always = DOUT.
//  irq registered-free: combinational from IRQ_STAT & IRQ_EN.
//  Reset mid-transfer: FSM to IDLE, PREADY=0 next cycle, pending write discarded.
// STRUCTURE
//  Package apb_gpio_pkg: register offset localparams, FSM state encoding (IDLE/SETUP/WAIT), WAIT cnt width.
//  Sub-module gpio_edge_detect: synchroniser + edge flop + IRQ_STAT set/clear; top holds APB FSM + regs.
// TESTING
//  1 Reset: PRESET=1 2 cycles -> PREADY=0, gpio_out=0, gpio_oe=0, irq=0.
//  2 WAIT_CYCLES=0: write 0xA5A5_0F0F to 0x00, then read 0x00 -> PREADY in first ACCESS cycle, PRDATA=0xA5A5_0F0F.
//  3 WAIT_CYCLES=3: write DIR=0xFFFF_0000 -> PREADY low 3 ACCESS cycles, high 4th; gpio_oe changes only then.
//  4 IRQ_POL[4]=1, IRQ_EN[4]=1, gpio_in[4] 0->1 -> IRQ_STAT=0x10 3 cycles later, irq=1; write 0x10 to 0x10 -> irq=0.
//  5 W1C of bit 4 in same cycle as new rising edge on pin 4 -> IRQ_STAT[4] stays 1.
//  6 Write 0x08 or read 0x18 -> PSLVERR=1 with PREADY, registers unchanged; PRESET mid-WAIT -> IDLE, write lost.

Source files
------------

// File: rtl/apb_gpio_pkg.sv
// Shared definitions for the APB GPIO completer: register map, FSM encoding
// and the latched-request record.
package apb_gpio_pkg;

  // Word index decoded from PADDR[4:2]
  localparam logic [2:0] REG_DOUT     = 3'd0;
  localparam logic [2:0] REG_DIR      = 3'd1;
  localparam logic [2:0] REG_DIN      = 3'd2;
  localparam logic [2:0] REG_IRQ_EN   = 3'd3;
  localparam logic [2:0] REG_IRQ_STAT = 3'd4;
  localparam logic [2:0] REG_IRQ_POL  = 3'd5;

  // APB transfer FSM; SETUP is the state holding a freshly latched request
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // Wait-state counter width (0..15 wait cycles)
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [2:0]  idx;
    logic        wr;
    logic [31:0] wdata;
  } apb_req_t;

  // Offsets 0x18 and 0x1C are holes in the map
  function automatic logic reg_is_valid(input logic [2:0] idx);
    return (idx <= REG_IRQ_POL);
  endfunction

endpackage

// File: rtl/apb_gpio_slave_edge_detect.sv
// Pad synchroniser, edge detector and sticky interrupt status.
// din_o is the second synchroniser flop; edges compare it to a third flop.
module gpio_edge_detect #(
  parameter int N_GPIO = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_GPIO-1:0] pad_i,
  input  logic [N_GPIO-1:0] pol_i,
  input  logic [N_GPIO-1:0] clr_i,
  output logic [N_GPIO-1:0] din_o,
  output logic [N_GPIO-1:0] stat_o
);

  logic [N_GPIO-1:0] sync1_q, sync2_q, prev_q;
  logic [N_GPIO-1:0] stat_q, stat_d;
  logic [N_GPIO-1:0] hit;

  // Edge match per pin and status update; a new edge beats a same-cycle W1C
  always_comb begin
    hit    = (pol_i & sync2_q & ~prev_q) | (~pol_i & ~sync2_q & prev_q);
    stat_d = (stat_q & ~clr_i) | hit;
  end

  // Synchroniser chain, edge history flop and status register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      stat_q  <= '0;
    end else begin
      sync1_q <= pad_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      stat_q  <= stat_d;
    end
  end

  assign din_o  = sync2_q;
  assign stat_o = stat_q;

endmodule

// File: rtl/apb_gpio_slave.sv
// APB3 completer for the GPIO block: transfer FSM with programmable wait
// states, register bank and level interrupt.
module apb_gpio_slave
  import apb_gpio_pkg::*;
#(
  parameter int N_GPIO      = 32,
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_W      = 32
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [N_GPIO-1:0] gpio_in,
  output logic [N_GPIO-1:0] gpio_out,
  output logic [N_GPIO-1:0] gpio_oe,
  output logic              irq
);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  apb_req_t          req_q, req_d;
  logic [N_GPIO-1:0] dout_q, dir_q, en_q, pol_q;
  logic [N_GPIO-1:0] din, stat, clr;
  logic [N_GPIO-1:0] wdata_n;
  logic              ready, req_err, wr_commit;
  logic [31:0]       rd_val;

  // Only PADDR[4:2] selects a register
  logic unused_addr;
  assign unused_addr = ^{PADDR[ADDR_W-1:5], PADDR[1:0]};

  function automatic logic [31:0] pad32(input logic [N_GPIO-1:0] v);
    logic [31:0] r;
    r = '0;
    r[N_GPIO-1:0] = v;
    return r;
  endfunction

  // Transfer FSM: latch on SETUP, count wait states, complete with PREADY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          req_d.idx   = PADDR[4:2];
          req_d.wr    = PWRITE;
          req_d.wdata = PWDATA;
          cnt_d       = CNT_W'(WAIT_CYCLES);
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP, ST_WAIT: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else if (!PENABLE) begin
          // Master abandoned the access phase and restarted: relatch
          req_d.idx   = PADDR[4:2];
          req_d.wr    = PWRITE;
          req_d.wdata = PWDATA;
          cnt_d       = CNT_W'(WAIT_CYCLES);
          state_d     = ST_SETUP;
        end else if (cnt_q == '0) begin
          ready   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response decode and read mux from the latched request
  always_comb begin
    req_err   = !reg_is_valid(req_q.idx) || (req_q.wr && (req_q.idx == REG_DIN));
    wr_commit = ready && req_q.wr && !req_err;
    wdata_n   = req_q.wdata[N_GPIO-1:0];
    clr       = (wr_commit && (req_q.idx == REG_IRQ_STAT)) ? wdata_n : '0;
    case (req_q.idx)
      REG_DOUT:     rd_val = pad32(dout_q);
      REG_DIR:      rd_val = pad32(dir_q);
      REG_DIN:      rd_val = pad32(din);
      REG_IRQ_EN:   rd_val = pad32(en_q);
      REG_IRQ_STAT: rd_val = pad32(stat);
      REG_IRQ_POL:  rd_val = pad32(pol_q);
      default:      rd_val = '0;
    endcase
    PREADY  = ready;
    PSLVERR = ready && req_err;
    PRDATA  = (ready && !req_q.wr && !req_err) ? rd_val : '0;
  end

  // FSM state and writable registers; writes land only on the PREADY cycle
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      dout_q  <= '0;
      dir_q   <= '0;
      en_q    <= '0;
      pol_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      if (wr_commit) begin
        case (req_q.idx)
          REG_DOUT:    dout_q <= wdata_n;
          REG_DIR:     dir_q  <= wdata_n;
          REG_IRQ_EN:  en_q   <= wdata_n;
          REG_IRQ_POL: pol_q  <= wdata_n;
          default:     ;
        endcase
      end
    end
  end

  gpio_edge_detect #(.N_GPIO(N_GPIO)) u_edge (
    .clk_i  (PCLK),
    .rst_i  (PRESET),
    .pad_i  (gpio_in),
    .pol_i  (pol_q),
    .clr_i  (clr),
    .din_o  (din),
    .stat_o (stat)
  );

  assign gpio_out = dout_q;
  assign gpio_oe  = dir_q;
  assign irq      = |(stat & en_q);

endmodule
